// File: rtl/bc_pkg.sv
// bc_pkg: shared types and defaults for the bc_arbiter counter sequencer.
//   state_t : FSM encoding (IDLE=0, CLR=1, RUN=2, DONE=3)
//   CW_DEF  : default counter / burst-length width
package bc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW_DEF = 4;

  // Index width for NREQ requesters (never zero, even for tiny NREQ).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bc_arbiter_if.sv
// bc_arbiter_if: requester and shared-counter signals of bc_arbiter.
//   req/len    : requester levels and flat burst lengths (slice i = len[i*CW +: CW])
//   gnt/done   : one-hot grant and completion pulse back to requesters
//   busy/err   : arbiter status
//   cnt_en/cnt_clear/cnt_in : shared counter control and fed-back count
// Modports: arb (the arbiter), cli (requesters + counter side / bench).
interface bc_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [CW-1:0]      cnt_in;
  logic               cnt_en;
  logic               cnt_clear;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               err;

  modport arb (
    input  req, len, cnt_in,
    output cnt_en, cnt_clear, gnt, done, busy, err
  );

  modport cli (
    output req, len, cnt_in,
    input  cnt_en, cnt_clear, gnt, done, busy, err
  );
endinterface

// File: rtl/bc_rr_pick.sv
// bc_rr_pick: combinational round-robin picker.
//   req : request vector
//   ptr : last granted index; search starts at ptr+1 and wraps
//   idx : chosen requester (valid when any=1)
//   any : at least one request set
module bc_rr_pick
  import bc_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Walk the distances from farthest to nearest so the nearest set bit
  // after ptr is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      int c;
      c = (int'(ptr) + k) % NREQ;
      if (req[c]) begin
        idx = IW'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bc_arbiter.sv
// bc_arbiter: round-robin arbiter that lends one shared CW-bit counter to
// NREQ requesters. Each grant runs CLR (clear counter), RUN (len cycles of
// count enable), DONE (check count, pulse done), then returns to IDLE.
//   clk     : rising-edge clock, shared with the counter
//   clear_n : asynchronous active-low reset
//   bus     : bc_arbiter_if.arb (req/len/cnt_in in; gnt/done/busy/err/cnt_* out)
// All outputs decode from registered state only.
module bc_arbiter
  import bc_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = CW_DEF,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic          clk,
  input  logic          clear_n,
  bc_arbiter_if.arb     bus
);

  state_t          state, state_d;
  logic [IW-1:0]   idx_q, ptr;
  logic [CW-1:0]   len_q, tick;
  logic            err_q;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  bc_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (pick_any) state_d = CLR;
      CLR:  state_d = (len_q != '0) ? RUN : DONE;
      RUN:  if (tick == CW'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      idx_q <= '0;
      ptr   <= IW'(NREQ - 1);
      len_q <= '0;
      tick  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: if (pick_any) begin
          idx_q <= pick_idx;
          len_q <= bus.len[pick_idx*CW +: CW];
        end
        CLR:  tick <= len_q;
        RUN:  tick <= tick - CW'(1);
        DONE: begin
          ptr <= idx_q;
          if (bus.cnt_in != len_q) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The counter only clears while enabled, so CLR asserts both.
  assign bus.cnt_en    = (state == CLR) || (state == RUN);
  assign bus.cnt_clear = (state == CLR);
  assign bus.busy      = (state != IDLE);
  assign bus.gnt       = (state != IDLE) ? (NREQ'(1) << idx_q) : '0;
  assign bus.done      = (state == DONE) ? (NREQ'(1) << idx_q) : '0;
  assign bus.err       = err_q;

endmodule
